// File: rtl/debounce_edge_if.sv
// debounce_edge_if
//   Groups the data-path signals of debounce_edge.
//   din  : raw asynchronous level (may bounce)
//   tick : sample-rate enable for the stability counter
//   dout : debounced, registered level
//   rise : one-cycle pulse on dout 0->1
//   fall : one-cycle pulse on dout 1->0
//   master drives din/tick and observes the outputs; slave is the debouncer.
interface debounce_edge_if;
    logic din;
    logic tick;
    logic dout;
    logic rise;
    logic fall;

    modport master (
        output din,
        output tick,
        input  dout,
        input  rise,
        input  fall
    );

    modport slave (
        input  din,
        input  tick,
        output dout,
        output rise,
        output fall
    );
endinterface

// File: rtl/debounce_edge.sv
// debounce_edge
//   Synchronises a raw bouncing level to clk, qualifies it with a stability
//   counter and presents a clean registered level plus rise/fall pulses.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   io  : debounce_edge_if.slave (din, tick in; dout, rise, fall out)
// Parameter:
//   STABLE : consecutive tick cycles a new level must persist (1..255)
module debounce_edge #(
    parameter int unsigned STABLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    debounce_edge_if.slave   io
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(STABLE - 1);

    logic       s1_q;
    logic       s2_q;
    state_e     state_q;
    logic [7:0] cnt_q;
    logic       dout_q;
    logic       rise_q;
    logic       fall_q;

    // Two-flop synchroniser; only s2_q feeds the qualification logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= io.din;
            s2_q <= s1_q;
        end
    end

    // Bounce detection is evaluated every clock; only the counter waits on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                ZERO: begin
                    if (s2_q) begin
                        state_q <= WAIT1;
                        cnt_q   <= '0;
                    end
                end
                WAIT1: begin
                    if (!s2_q) begin
                        state_q <= ZERO;
                    end else if (io.tick) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ONE;
                            dout_q  <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                ONE: begin
                    if (!s2_q) begin
                        state_q <= WAIT0;
                        cnt_q   <= '0;
                    end
                end
                WAIT0: begin
                    if (s2_q) begin
                        state_q <= ONE;
                    end else if (io.tick) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ZERO;
                            dout_q  <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ZERO;
                end
            endcase
        end
    end

    assign io.dout = dout_q;
    assign io.rise = rise_q;
    assign io.fall = fall_q;

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge
//   Drives three debouncers (STABLE = 4, 2, 1) from shared stimulus and
//   checks each against a run-length reference model via a scoreboard queue.
module tb_debounce_edge;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic din  = 1'b0;
    logic tick = 1'b1;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned STB = (g == 0) ? 4 : (g == 1) ? 2 : 1;

        debounce_edge_if u_if ();
        assign u_if.din  = din;
        assign u_if.tick = tick;

        debounce_edge #(.STABLE(STB)) u_dut (
            .clk (clk),
            .rst (rst),
            .io  (u_if)
        );

        // Reference: the synchronised level is din delayed two edges. A level
        // differing from the reported one is accepted once it has persisted
        // for STABLE ticked edges after the edge on which it was first seen.
        logic        m_s1   = 1'b0;
        logic        m_s2   = 1'b0;
        logic        m_out  = 1'b0;
        int unsigned age    = 0;
        int unsigned ticked = 0;
        logic        m_r;
        logic        m_f;
        logic [2:0]  q[$];
        logic [2:0]  exp_v;
        logic [2:0]  act_v;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_s1   = 1'b0;
                m_s2   = 1'b0;
                m_out  = 1'b0;
                age    = 0;
                ticked = 0;
                q.delete();
            end else begin
                m_r = 1'b0;
                m_f = 1'b0;
                if (m_s2 != m_out) begin
                    age = age + 1;
                    if (age > 1 && tick) ticked = ticked + 1;
                    if (ticked == STB) begin
                        m_out  = m_s2;
                        m_r    = m_out;
                        m_f    = !m_out;
                        age    = 0;
                        ticked = 0;
                    end
                end else begin
                    age    = 0;
                    ticked = 0;
                end
                m_s2 = m_s1;
                m_s1 = din;
                q.push_back({m_out, m_r, m_f});
            end
        end

        always @(negedge clk) begin
            act_v = {u_if.dout, u_if.rise, u_if.fall};
            if (rst || q.size() == 0) exp_v = 3'b000;
            else                      exp_v = q.pop_front();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL stable%0d_outputs cyc=%0d got dout/rise/fall=%b want %b",
                         STB, cyc, act_v, exp_v);
            end
            checks++;
            if (u_if.rise === 1'b1 && u_if.fall === 1'b1) begin
                errors++;
                $display("FAIL stable%0d_both_pulses cyc=%0d got rise=1 fall=1 want not both",
                         STB, cyc);
            end
        end
    end

    // Inputs change 2 time units after a rising edge, well clear of sampling.
    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic hold(input logic v, input int unsigned n);
        din = v;
        step(n);
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(3);

        // Clean rise and fall, per-clock ticks.
        hold(1'b1, 12);
        hold(1'b0, 12);

        // Bounce 1,0,1,0 then settle high; mirror going low.
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
        hold(1'b1, 12);
        hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1);
        hold(1'b0, 12);

        // Sub-threshold glitch from a high level.
        hold(1'b1, 12);
        hold(1'b0, 3);
        hold(1'b1, 12);
        hold(1'b0, 12);

        // Sparse tick: one cycle in four.
        for (int unsigned k = 0; k < 4; k++) begin
            din = (k % 2 == 0);
            for (int unsigned i = 0; i < 24; i++) begin
                tick = (i % 4 == 0);
                step(1);
            end
        end
        tick = 1'b1;
        hold(1'b0, 12);

        // Reset mid-qualification, then power-on-high behaviour.
        hold(1'b1, 4);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(15);
        hold(1'b0, 12);

        // Toggle every 3 clocks.
        for (int unsigned i = 0; i < 12; i++) hold(i[0] == 1'b0, 3);
        hold(1'b0, 10);

        // Randomised level durations and tick density, with occasional reset.
        for (int unsigned i = 0; i < 400; i++) begin
            din = ~din;
            for (int unsigned j = $urandom_range(1, 9); j > 0; j--) begin
                tick = ($urandom_range(0, 3) != 0);
                step(1);
            end
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
        end
        tick = 1'b1;
        hold(1'b0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
